// File: rtl/rv32i_inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_inst_encoder: two-stage RV32I field-bundle to instruction encoder.  |
// | Define RV32I_ENCODER_CHECK_EN to flag unencodable bundles on out_err.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rv32i_inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err
);

  localparam logic [6:0] C_OP_OP     = 7'h33;
  localparam logic [6:0] C_OP_IMM    = 7'h13;
  localparam logic [6:0] C_OP_LOAD   = 7'h03;
  localparam logic [6:0] C_OP_JALR   = 7'h67;
  localparam logic [6:0] C_OP_SYSTEM = 7'h73;
  localparam logic [6:0] C_OP_FENCE  = 7'h0F;
  localparam logic [6:0] C_OP_STORE  = 7'h23;
  localparam logic [6:0] C_OP_LUI    = 7'h37;
  localparam logic [6:0] C_OP_AUIPC  = 7'h17;
  localparam logic [6:0] C_OP_JAL    = 7'h6F;
  localparam logic [6:0] C_OP_BRANCH = 7'h63;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_SH = 3'd2,
    FMT_S  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_B  = 3'd6,
    FMT_X  = 3'd7
  } fmt_e;

  function automatic fmt_e classify(input logic [6:0] op, input logic [2:0] f3);
    fmt_e f;
    case (op)
      C_OP_OP:     f = FMT_R;
      C_OP_IMM:    f = (f3 == 3'd1 || f3 == 3'd5) ? FMT_SH : FMT_I;
      C_OP_LOAD,
      C_OP_JALR,
      C_OP_SYSTEM,
      C_OP_FENCE:  f = FMT_I;
      C_OP_STORE:  f = FMT_S;
      C_OP_LUI,
      C_OP_AUIPC:  f = FMT_U;
      C_OP_JAL:    f = FMT_J;
      C_OP_BRANCH: f = FMT_B;
      default:     f = FMT_X;
    endcase
    return f;
  endfunction

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [6:0]  s1_op_q,    s1_op_d;
  logic [4:0]  s1_rd_q,    s1_rd_d;
  logic [4:0]  s1_rs1_q,   s1_rs1_d;
  logic [4:0]  s1_rs2_q,   s1_rs2_d;
  logic [2:0]  s1_f3_q,    s1_f3_d;
  logic [6:0]  s1_f7_q,    s1_f7_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  fmt_e        s1_fmt_q,   s1_fmt_d;

  // Stage 2 state
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q,  out_inst_d;
  logic        out_err_q,   out_err_d;

  logic        s2_can_load;
  logic [31:0] enc_inst;
  logic        enc_err;

  assign s2_can_load = !out_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_err     = out_err_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_f3_d    = s1_f3_q;
    s1_f7_d    = s1_f7_q;
    s1_imm_d   = s1_imm_q;
    s1_fmt_d   = s1_fmt_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      s1_op_d  = in_opcode;
      s1_rd_d  = in_rd;
      s1_rs1_d = in_rs1;
      s1_rs2_d = in_rs2;
      s1_f3_d  = in_funct3;
      s1_f7_d  = in_funct7;
      s1_imm_d = in_imm;
      s1_fmt_d = classify(in_opcode, in_funct3);
    end
  end

  // Unknown opcodes fall through to the I-type packing.
  always_comb begin
    enc_inst = '0;
    case (s1_fmt_q)
      FMT_R:  enc_inst = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_SH: enc_inst = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S:  enc_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:0], s1_op_q};
      FMT_U:  enc_inst = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FMT_J:  enc_inst = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                          s1_imm_q[19:12], s1_rd_q, s1_op_q};
      FMT_B:  enc_inst = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      default: enc_inst = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
    endcase
  end

`ifdef RV32I_ENCODER_CHECK_EN
  logic imm12_ok;
  logic imm13_ok;
  logic imm21_ok;

  assign imm12_ok = (s1_imm_q[31:11] == {21{s1_imm_q[11]}});
  assign imm13_ok = (s1_imm_q[31:12] == {20{s1_imm_q[12]}}) && !s1_imm_q[0];
  assign imm21_ok = (s1_imm_q[31:20] == {12{s1_imm_q[20]}}) && !s1_imm_q[0];

  always_comb begin
    enc_err = 1'b0;
    case (s1_fmt_q)
      FMT_I,
      FMT_S:  enc_err = !imm12_ok;
      FMT_SH: enc_err = !imm12_ok || (s1_imm_q[11:5] != 7'd0);
      FMT_U:  enc_err = (s1_imm_q[11:0] != 12'd0);
      FMT_J:  enc_err = !imm21_ok;
      FMT_B:  enc_err = !imm13_ok;
      FMT_X:  enc_err = 1'b1;
      default: enc_err = 1'b0;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    if (s2_can_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_inst_d = enc_err ? 32'h0000_0000 : enc_inst;
        out_err_d  = enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      s1_imm_q    <= '0;
      s1_fmt_q    <= FMT_I;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f3_q     <= s1_f3_d;
      s1_f7_q     <= s1_f7_d;
      s1_imm_q    <= s1_imm_d;
      s1_fmt_q    <= s1_fmt_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule
`default_nettype wire
